rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq.sv | 139 +++++++++++++
 tb/tb_rst_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// rst_seq -- reset sequencer.
//
// Generates a stretched, registered reset (rst_out) from three sources:
//   - the module reset rst (synchronous, active-high, highest priority),
//   - a software request sw_req (one-cycle pulse),
//   - an external push-button btn (asynchronous, debounced by a filter).
//
// Ports:
//   clk        in   single clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset; restarts the full stretch
//   btn        in   asynchronous active-high push-button
//   sw_req     in   synchronous active-high software reset request
//   rst_out    out  registered generated reset, high for STRETCH cycles
//   busy       out  registered, high while filtering or asserting
//   rst_count  out  accepted btn/sw_req reset events, saturating at 255
//
// Parameters:
//   STRETCH  cycles rst_out stays high per event (2..255)
//   FILTER   consecutive synchronized-high btn samples to accept (1..15)
module rst_seq #(
  parameter int STRETCH = 16,
  parameter int FILTER  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       sw_req,
  output logic       rst_out,
  output logic       busy,
  output logic [7:0] rst_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILTER,
    S_ASSERT,
    S_WAIT_REL
  } state_t;

  localparam logic [7:0] STRETCH_LAST = 8'(STRETCH - 1);
  localparam logic [3:0] FILTER_LAST  = 4'(FILTER - 1);

  state_t     state;
  logic [7:0] stretch_cnt;
  logic [3:0] filter_cnt;
  logic       btn_meta;
  logic       btn_s;
  logic [7:0] count_inc;

  // Saturating increment used on every accepted entry into ASSERT.
  assign count_inc = (rst_count == 8'hFF) ? rst_count : rst_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Holding rst keeps the stretch counter at zero, so the full
      // STRETCH-cycle stretch is counted from the last reset edge.
      btn_meta    <= 1'b0;
      btn_s       <= 1'b0;
      state       <= S_ASSERT;
      stretch_cnt <= 8'd0;
      filter_cnt  <= 4'd0;
      rst_count   <= 8'd0;
      rst_out     <= 1'b1;
      busy        <= 1'b1;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;

      case (state)
        S_IDLE: begin
          if (sw_req || (btn_s && FILTER == 1)) begin
            state       <= S_ASSERT;
            stretch_cnt <= 8'd0;
            filter_cnt  <= 4'd0;
            rst_out     <= 1'b1;
            busy        <= 1'b1;
            rst_count   <= count_inc;
          end else if (btn_s) begin
            state      <= S_FILTER;
            filter_cnt <= 4'd1;
            busy       <= 1'b1;
          end
        end

        S_FILTER: begin
          // sw_req wins over the button filter; a completed filter count
          // also enters ASSERT on this same edge.
          if (sw_req || (btn_s && filter_cnt == FILTER_LAST)) begin
            state       <= S_ASSERT;
            stretch_cnt <= 8'd0;
            filter_cnt  <= 4'd0;
            rst_out     <= 1'b1;
            busy        <= 1'b1;
            rst_count   <= count_inc;
          end else if (!btn_s) begin
            state      <= S_IDLE;
            filter_cnt <= 4'd0;
            busy       <= 1'b0;
          end else begin
            filter_cnt <= filter_cnt + 4'd1;
          end
        end

        S_ASSERT: begin
          // sw_req/btn are deliberately ignored here: no restart, no count.
          if (stretch_cnt == STRETCH_LAST) begin
            state       <= S_WAIT_REL;
            stretch_cnt <= 8'd0;
            rst_out     <= 1'b0;
            busy        <= 1'b0;
          end else begin
            stretch_cnt <= stretch_cnt + 8'd1;
          end
        end

        S_WAIT_REL: begin
          // A still-held button must be released before it can retrigger.
          if (sw_req) begin
            state       <= S_ASSERT;
            stretch_cnt <= 8'd0;
            filter_cnt  <= 4'd0;
            rst_out     <= 1'b1;
            busy        <= 1'b1;
            rst_count   <= count_inc;
          end else if (!btn_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state   <= S_IDLE;
          rst_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq. Stimulus pushes the expected rst_out pulse
// (start edge, length, rst_count at the end) into a queue; an independent
// monitor measures each pulse the DUT produces and compares on its fall.
module tb_rst_seq;

  localparam int STRETCH = 16;
  localparam int FILTER  = 4;

  typedef struct {
    int start;
    int len;
    int cnt;
  } pulse_t;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       sw_req;
  logic       rst_out;
  logic       busy;
  logic [7:0] rst_count;

  int vectors;
  int miscompares;
  int cyc;
  int exp_cnt;
  pulse_t exp_q[$];

  rst_seq #(.STRETCH(STRETCH), .FILTER(FILTER)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .sw_req    (sw_req),
    .rst_out   (rst_out),
    .busy      (busy),
    .rst_count (rst_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Number of rising edges seen so far.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pulse(input int start, input int len, input int cnt);
    pulse_t p;
    p.start = start;
    p.len   = len;
    p.cnt   = cnt;
    exp_q.push_back(p);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Monitor: measures each rst_out pulse, sampled on the falling edge.
  initial begin : monitor
    bit     in_pulse;
    int     st;
    int     len;
    bit     busy_ok;
    pulse_t e;
    in_pulse = 1'b0;
    st = 0;
    len = 0;
    busy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_out === 1'b1) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          st       = cyc;
          len      = 0;
          busy_ok  = 1'b1;
        end
        len = len + 1;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_start", st, -1);
        end else begin
          e = exp_q.pop_front();
          $display("pulse start=%0d len=%0d count=%0d (exp start=%0d len=%0d count=%0d)",
                   st, len, rst_count, e.start, e.len, e.cnt);
          chk("pulse_start", st, e.start);
          chk("pulse_len", len, e.len);
          chk("rst_count", int'(rst_count), e.cnt);
          chk("busy_during_pulse", int'(busy_ok), 1);
          chk("busy_after_pulse", int'(busy === 1'b1), 0);
        end
      end
    end
  end

  task automatic sw_pulse();
    int n;
    n = cyc;
    sw_req = 1'b1;
    exp_cnt = sat_inc(exp_cnt);
    push_pulse(n + 1, STRETCH, exp_cnt);
    @(negedge clk);
    sw_req = 1'b0;
  endtask

  task automatic btn_press(input int hold, input bit expect_pulse);
    int n;
    n = cyc;
    btn = 1'b1;
    if (expect_pulse) begin
      exp_cnt = sat_inc(exp_cnt);
      push_pulse(n + 2 + FILTER, STRETCH, exp_cnt);
    end
    repeat (hold) @(negedge clk);
    btn = 1'b0;
  endtask

  initial begin : stim
    int n;
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = 0;
    rst    = 1'b1;
    btn    = 1'b0;
    sw_req = 1'b0;

    // Power-on: three reset edges, then STRETCH more high cycles.
    push_pulse(1, 3 - 1 + STRETCH, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    // Software request from IDLE.
    sw_pulse();
    repeat (25) @(negedge clk);

    // Button glitch shorter than the filter: no pulse expected.
    btn_press(3, 1'b0);
    repeat (15) @(negedge clk);

    // Clean button press.
    btn_press(10, 1'b1);
    repeat (30) @(negedge clk);

    // Held button gives one pulse; release and press again for a second.
    btn_press(100, 1'b1);
    repeat (10) @(negedge clk);
    btn_press(10, 1'b1);
    repeat (30) @(negedge clk);

    // sw_req and btn during ASSERT are ignored.
    sw_pulse();
    repeat (3) @(negedge clk);
    sw_req = 1'b1;
    btn    = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    btn    = 1'b0;
    repeat (25) @(negedge clk);

    // rst mid-ASSERT: count clears, full stretch after the reset edge.
    n = cyc;
    sw_req = 1'b1;
    exp_cnt = 0;
    push_pulse(n + 1, 5 + STRETCH, 0);
    @(negedge clk);
    sw_req = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // rst mid-FILTER: pulse starts at the reset edge, no count.
    n = cyc;
    btn = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    push_pulse(n + 5, STRETCH, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Saturation: 300 requests, 20 cycles apart.
    for (int i = 0; i < 300; i++) begin
      sw_pulse();
      repeat (19) @(negedge clk);
    end
    repeat (30) @(negedge clk);

    chk("pending_pulses", exp_q.size(), 0);
    chk("final_rst_count", int'(rst_count), 255);
    chk("final_rst_out", int'(rst_out === 1'b1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
